// File: rtl/mem_stage_if.sv
// Memory-side bus of the MEM stage: one outstanding request at a time.
//
// Handshake: the master holds mem_req_o high together with a stable
// mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o until the slave returns
// mem_ack_i for exactly one cycle; the access completes on the rising edge
// where mem_req_o (or the pending access) and mem_ack_i are both seen.
// For loads mem_rdata_i must be valid in the same cycle as mem_ack_i.
// mem_ack_i while no access is pending carries no meaning and is ignored.
interface mem_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    // Pipeline side issuing accesses
    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_be_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    // Memory side answering accesses
    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_be_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns a load/store from EX/MEM into a word-aligned
// memory access, stalls the front of the pipeline until the memory
// answers (or a timeout fires), and formats load data for MEM/WB.
// The FSM state is exported on state_o for observation.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    mem_stage_if.master mem,
    output logic [31:0] MemRdata_o,
    output logic        stall_o,
    output logic        access_err_o,
    output logic        timeout_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;

    logic        valid;
    logic        is_store;
    logic        legal;
    logic        accept;
    logic        reject;
    logic        wait_expired;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] rd_shifted;
    logic [31:0] ld_data;

    // A simultaneous read and write request is handled as a store
    assign valid    = MemRead_i | MemWrite_i;
    assign is_store = MemWrite_i;

    // Alignment and encoding check of the incoming access
    always_comb begin
        legal = 1'b0;
        case (funct3_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr_i[0];
            3'b010:  legal = (addr_i[1:0] == 2'b00);
            3'b100:  legal = ~is_store;
            3'b101:  legal = ~is_store & ~addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    assign accept       = (state_q == IDLE) & valid & legal;
    assign reject       = (state_q == IDLE) & valid & ~legal;
    assign wait_expired = (state_q == WAIT) & (cnt_q == TMO);

    // Store lane replication and byte enables; loads always read the full word
    always_comb begin
        st_wdata = wdata_i;
        st_be    = 4'b1111;
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00: begin
                    st_wdata = {4{wdata_i[7:0]}};
                    st_be    = 4'b0001 << addr_i[1:0];
                end
                2'b01: begin
                    st_wdata = {2{wdata_i[15:0]}};
                    st_be    = 4'b0011 << addr_i[1:0];
                end
                default: begin
                    st_wdata = wdata_i;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Select the addressed byte/half of the read word and extend it
    assign rd_shifted = mem.mem_rdata_i >> {addr_lo_q, 3'b000};

    always_comb begin
        ld_data = mem.mem_rdata_i;
        case (funct3_q)
            3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  ld_data = {24'd0, rd_shifted[7:0]};
            3'b101:  ld_data = {16'd0, rd_shifted[15:0]};
            default: ld_data = mem.mem_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and combinational stage outputs
    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b0;
        mem.mem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    stall_o = 1'b1;
                end
            end
            WAIT: begin
                stall_o       = 1'b1;
                // The request is withdrawn in the cycle the wait budget runs out
                mem.mem_req_o = ~wait_expired;
                if (mem.mem_ack_i || wait_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The pipeline advances now; the old access must not restart
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst_i) begin
            stall_o = 1'b0;
        end
    end

    assign state_o = state_q;

    // Access capture, wait counter, load result and status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q           <= '0;
            addr_lo_q       <= '0;
            funct3_q        <= '0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_be_o    <= '0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
            MemRdata_o      <= '0;
            access_err_o    <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            access_err_o <= reject;
            if (accept) begin
                cnt_q           <= '0;
                addr_lo_q       <= addr_i[1:0];
                funct3_q        <= funct3_i;
                mem.mem_we_o    <= is_store;
                mem.mem_be_o    <= st_be;
                mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
                mem.mem_wdata_o <= st_wdata;
            end
            if (reject) begin
                MemRdata_o <= '0;
            end
            if (state_q == WAIT) begin
                if (mem.mem_ack_i) begin
                    // An ack arriving with the expiring count still completes normally
                    if (!mem.mem_we_o) begin
                        MemRdata_o <= ld_data;
                    end
                end else if (wait_expired) begin
                    timeout_o  <= 1'b1;
                    MemRdata_o <= '0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): each task drives one scenario
// and compares outputs against hand-computed values.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata_out;
    logic        stall;
    logic        access_err;
    logic        timeout;
    logic [1:0]  state;

    int n_vec  = 0;
    int n_fail = 0;

    mem_stage_if mem_bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .MemRead_i    (mem_read),
        .MemWrite_i   (mem_write),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .mem          (mem_bus),
        .MemRdata_o   (mem_rdata_out),
        .stall_o      (stall),
        .access_err_o (access_err),
        .timeout_o    (timeout),
        .state_o      (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        funct3              = 3'b000;
        addr                = 32'd0;
        wdata               = 32'd0;
        mem_bus.mem_ack_i   = 1'b0;
        mem_bus.mem_rdata_i = 32'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go_idle();
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    // Driver: holds the access on the inputs until the DONE cycle and acks on
    // wait cycle ack_at (1 = first cycle after acceptance, 0 = never).
    // Returns in the DONE cycle, inputs still applied.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdat,
                             output int stalls, output int reqs,
                             output logic [31:0] s_addr, output logic [31:0] s_wdata,
                             output logic [3:0] s_be, output logic s_we);
        bit done;
        done    = 1'b0;
        stalls  = 0;
        reqs    = 0;
        s_addr  = '0;
        s_wdata = '0;
        s_be    = '0;
        s_we    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mem_read            = rd;
            mem_write           = wr;
            funct3              = f3;
            addr                = a;
            wdata               = wd;
            mem_bus.mem_ack_i   = (ack_at != 0) && (c == ack_at);
            mem_bus.mem_rdata_i = rdat;
            #1;
            if (c > 0 && !stall) begin
                done = 1'b1;
            end else begin
                if (stall) stalls++;
                if (mem_bus.mem_req_o) reqs++;
            end
            if (c == 1) begin
                s_addr  = mem_bus.mem_addr_o;
                s_wdata = mem_bus.mem_wdata_o;
                s_be    = mem_bus.mem_be_o;
                s_we    = mem_bus.mem_we_o;
            end
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL access_bound: stall still high after 40 cycles, required release");
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0;
        mem_bus.mem_ack_i = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b need 0", stall); end
        @(negedge clk);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall2: got %b need 0", stall); end
        n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d need 0", state); end
        n_vec++; if (mem_bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b need 0", mem_bus.mem_req_o); end
        n_vec++; if (mem_bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b need 0", mem_bus.mem_we_o); end
        n_vec++; if (mem_bus.mem_be_o !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %b need 0000", mem_bus.mem_be_o); end
        n_vec++; if (mem_bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h need 0", mem_bus.mem_addr_o); end
        n_vec++; if (mem_bus.mem_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h need 0", mem_bus.mem_wdata_o); end
        n_vec++; if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h need 0", mem_rdata_out); end
        n_vec++; if (access_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", access_err); end
        n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b need 0", timeout); end
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d need 0", state); end
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        n_vec++; if (mem_bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_ack_req: got %b need 0", mem_bus.mem_req_o); end
        go_idle();
        n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_ack_state: got %0d need 0", state); end
        n_vec++; if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL idle_ack_rdata: got %h need 0", mem_rdata_out); end
    endtask

    task automatic test_lb();
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 3, 32'h80FF_1234, st, rq, sa, sw, sb, swe);
        n_vec++; if (sa !== 32'h0000_0100) begin n_fail++; $display("FAIL lb_addr: got %h need 00000100", sa); end
        n_vec++; if (sb !== 4'b1111) begin n_fail++; $display("FAIL lb_be: got %b need 1111", sb); end
        n_vec++; if (swe !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b need 0", swe); end
        n_vec++; if (st != 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d need 4", st); end
        n_vec++; if (rq != 3) begin n_fail++; $display("FAIL lb_req_cycles: got %0d need 3", rq); end
        n_vec++; if (mem_rdata_out !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h need ffffff80", mem_rdata_out); end
        n_vec++; if (state !== 2'd2) begin n_fail++; $display("FAIL lb_done_state: got %0d need 2", state); end
        n_vec++; if (mem_bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL lb_done_req: got %b need 0", mem_bus.mem_req_o); end
        go_idle();
        n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL lb_no_reissue: got state %0d need 0", state); end
    endtask

    task automatic test_sh();
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 1, 32'h0, st, rq, sa, sw, sb, swe);
        n_vec++; if (sa !== 32'h0000_0020) begin n_fail++; $display("FAIL sh_addr: got %h need 00000020", sa); end
        n_vec++; if (sb !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b need 1100", sb); end
        n_vec++; if (sw !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h need beefbeef", sw); end
        n_vec++; if (swe !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b need 1", swe); end
        n_vec++; if (st != 2) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d need 2", st); end
        n_vec++; if (mem_rdata_out !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL sh_rdata_hold: got %h need ffffff80", mem_rdata_out); end
        go_idle();
    endtask

    task automatic test_sb_both();
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        do_access(1'b1, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 2, 32'h0, st, rq, sa, sw, sb, swe);
        n_vec++; if (sb !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b need 0010", sb); end
        n_vec++; if (sw !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h need a5a5a5a5", sw); end
        n_vec++; if (swe !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b need 1", swe); end
        n_vec++; if (sa !== 32'h0000_0300) begin n_fail++; $display("FAIL sb_addr: got %h need 00000300", sa); end
        go_idle();
    endtask

    task automatic test_illegal();
        logic [2:0]  t_f3 [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
        logic [31:0] t_a  [4] = '{32'h41, 32'h0, 32'h0, 32'h23};
        logic        t_wr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_read  = ~t_wr[i];
            mem_write = t_wr[i];
            funct3    = t_f3[i];
            addr      = t_a[i];
            wdata     = 32'hFFFF_FFFF;
            #1;
            n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_stall: got %b need 0", i, stall); end
            n_vec++; if (mem_bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_req: got %b need 0", i, mem_bus.mem_req_o); end
            go_idle();
            n_vec++; if (access_err !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_err: got %b need 1", i, access_err); end
            n_vec++; if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL illegal%0d_rdata: got %h need 0", i, mem_rdata_out); end
            n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL illegal%0d_state: got %0d need 0", i, state); end
            @(negedge clk);
            #1;
            n_vec++; if (access_err !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_pulse: got %b need 0", i, access_err); end
        end
    endtask

    task automatic test_load_formats();
        logic [2:0]  t_f3  [6] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b101, 3'b000};
        logic [31:0] t_a   [6] = '{32'h0, 32'h2, 32'h1, 32'h4, 32'h0, 32'h2};
        logic [31:0] t_rd  [6] = '{32'h0000_007F, 32'h8001_0000, 32'h0000_F000,
                                   32'h1234_5678, 32'h0000_8001, 32'h00A5_0000};
        logic [31:0] t_exp [6] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_00F0,
                                   32'h1234_5678, 32'h0000_8001, 32'hFFFF_FFA5};
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        for (int i = 0; i < 6; i++) begin
            do_access(1'b1, 1'b0, t_f3[i], t_a[i], 32'h0, 1, t_rd[i], st, rq, sa, sw, sb, swe);
            n_vec++; if (mem_rdata_out !== t_exp[i]) begin n_fail++; $display("FAIL load%0d_rdata: got %h need %h", i, mem_rdata_out, t_exp[i]); end
            go_idle();
        end
    endtask

    task automatic test_back_to_back();
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0, 1, 32'h9ABC_0000, st, rq, sa, sw, sb, swe);
        n_vec++; if (mem_rdata_out !== 32'h0000_9ABC) begin n_fail++; $display("FAIL b2b_lhu_rdata: got %h need 00009abc", mem_rdata_out); end
        n_vec++; if (sa !== 32'h0000_0010) begin n_fail++; $display("FAIL b2b_lhu_addr: got %h need 00000010", sa); end
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 2, 32'h0, st, rq, sa, sw, sb, swe);
        n_vec++; if (st != 3) begin n_fail++; $display("FAIL b2b_sw_stall_cycles: got %0d need 3", st); end
        n_vec++; if (rq != 2) begin n_fail++; $display("FAIL b2b_sw_req_cycles: got %0d need 2", rq); end
        n_vec++; if (sw !== 32'h1122_3344) begin n_fail++; $display("FAIL b2b_sw_wdata: got %h need 11223344", sw); end
        n_vec++; if (sb !== 4'b1111) begin n_fail++; $display("FAIL b2b_sw_be: got %b need 1111", sb); end
        n_vec++; if (swe !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_we: got %b need 1", swe); end
        n_vec++; if (mem_rdata_out !== 32'h0000_9ABC) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h need 00009abc", mem_rdata_out); end
        go_idle();
    endtask

    task automatic test_timeout();
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 0, 32'h5555_5555, st, rq, sa, sw, sb, swe);
        n_vec++; if (rq != 4) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d need 4", rq); end
        n_vec++; if (st != 6) begin n_fail++; $display("FAIL tmo_stall_cycles: got %0d need 6", st); end
        n_vec++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b need 1", timeout); end
        n_vec++; if (state !== 2'd2) begin n_fail++; $display("FAIL tmo_state: got %0d need 2", state); end
        n_vec++; if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata: got %h need 0", mem_rdata_out); end
        go_idle();
        @(negedge clk);
        #1;
        n_vec++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b need 1", timeout); end
    endtask

    task automatic test_timeout_ack();
        int st, rq;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;
        apply_reset();
        #1;
        n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_clear: got %b need 0", timeout); end
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_000C, 32'h0, 5, 32'hCAFE_F00D, st, rq, sa, sw, sb, swe);
        n_vec++; if (rq != 4) begin n_fail++; $display("FAIL tmoack_req_cycles: got %0d need 4", rq); end
        n_vec++; if (st != 6) begin n_fail++; $display("FAIL tmoack_stall_cycles: got %0d need 6", st); end
        n_vec++; if (mem_rdata_out !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tmoack_rdata: got %h need cafef00d", mem_rdata_out); end
        n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmoack_flag: got %b need 0", timeout); end
        go_idle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        #1;
        n_vec++; if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL rmw_reset_rdata: got %h need 0", mem_rdata_out); end
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0010;
        @(negedge clk);
        #1;
        n_vec++; if (mem_bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rmw_req_before: got %b need 1", mem_bus.mem_req_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmw_stall_in_reset: got %b need 0", stall); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL rmw_state: got %0d need 0", state); end
        n_vec++; if (mem_bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rmw_req: got %b need 0", mem_bus.mem_req_o); end
        go_idle();
        n_vec++; if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL rmw_rdata: got %h need 0", mem_rdata_out); end
        n_vec++; if (state !== 2'd0) begin n_fail++; $display("FAIL rmw_state_after: got %0d need 0", state); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_ack_idle();
        test_lb();
        test_sh();
        test_sb_both();
        test_illegal();
        test_load_formats();
        test_back_to_back();
        test_timeout();
        test_timeout_ack();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
